// File: rtl/water_level_pkg.sv
// rtl/water_level_pkg.sv - shared FSM states, level encodings and pattern check
package water_level_pkg;

   typedef enum logic [1:0] {INIT, RUN, HOLD, FAULT} state_e;

   // Level patterns are {low, mid, high}; a wetter probe implies every lower probe is wet.
   localparam logic [2:0] LVL_EMPTY = 3'b000;
   localparam logic [2:0] LVL_LOW   = 3'b100;
   localparam logic [2:0] LVL_MID   = 3'b110;
   localparam logic [2:0] LVL_FULL  = 3'b111;

   function automatic logic is_valid_level(input logic [2:0] lvl);
      return (lvl == LVL_EMPTY) || (lvl == LVL_LOW) || (lvl == LVL_MID) || (lvl == LVL_FULL);
   endfunction

endpackage

// File: rtl/probe_debouncer.sv
// rtl/probe_debouncer.sv - two-flop synchroniser plus debounce filter for one probe
module probe_debouncer
   import water_level_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic stable_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   logic          sync1_q;
   logic          sync2_q;
   logic          stable_q;
   logic [CW-1:0] cnt_q;

   // The stable value only moves after DEBOUNCE_CYCLES back-to-back disagreeing samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         if (sync2_q == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable_q <= sync2_q;
            cnt_q    <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/water_level_sensor_conditioner.sv
// rtl/water_level_sensor_conditioner.sv - debounced, consistency-checked tank level for the pump controller
module water_level_sensor_conditioner
   import water_level_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FAULT_CYCLES    = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic probe_low_raw,
   input  logic probe_mid_raw,
   input  logic probe_high_raw,
   output logic low,
   output logic mid,
   output logic high,
   output logic level_valid,
   output logic level_change,
   output logic sensor_fault
);

   localparam int IW = $clog2(DEBOUNCE_CYCLES + 2);
   localparam int FW = $clog2(FAULT_CYCLES);

   logic [2:0]    lvl_s;
   logic          lvl_ok;
   state_e        state_q, state_d;
   logic [IW-1:0] init_cnt_q, init_cnt_d;
   logic [FW-1:0] bad_cnt_q, bad_cnt_d;
   logic [2:0]    out_q, out_d;
   logic          change_q;

   probe_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_low (
      .clk(clk), .reset(reset), .raw_i(probe_low_raw),  .stable_o(lvl_s[2]));
   probe_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mid (
      .clk(clk), .reset(reset), .raw_i(probe_mid_raw),  .stable_o(lvl_s[1]));
   probe_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_high (
      .clk(clk), .reset(reset), .raw_i(probe_high_raw), .stable_o(lvl_s[0]));

   assign lvl_ok = is_valid_level(lvl_s);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= INIT;
         init_cnt_q <= '0;
         bad_cnt_q  <= '0;
         out_q      <= LVL_EMPTY;
         change_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         bad_cnt_q  <= bad_cnt_d;
         out_q      <= out_d;
         change_q   <= (out_d != out_q);
      end
   end

   // INIT waits long enough for the synchronisers and debouncers to settle from reset.
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      bad_cnt_d  = bad_cnt_q;
      case (state_q)
         INIT: begin
            if (init_cnt_q == IW'(DEBOUNCE_CYCLES + 1)) begin
               state_d    = lvl_ok ? RUN : HOLD;
               init_cnt_d = '0;
            end else begin
               init_cnt_d = init_cnt_q + 1'b1;
            end
         end
         RUN: begin
            bad_cnt_d = '0;
            if (!lvl_ok) state_d = HOLD;
         end
         HOLD: begin
            if (lvl_ok) begin
               state_d   = RUN;
               bad_cnt_d = '0;
            end else if (bad_cnt_q == FW'(FAULT_CYCLES - 1)) begin
               state_d = FAULT;
            end else begin
               bad_cnt_d = bad_cnt_q + 1'b1;
            end
         end
         default: state_d = FAULT;
      endcase
   end

   // Outputs load on the edge the FSM commits to RUN/FAULT so flags and level move together.
   always_comb begin
      out_d = out_q;
      if (state_d == FAULT)    out_d = LVL_FULL;
      else if (state_d == RUN) out_d = lvl_s;
      level_valid  = (state_q == RUN) || (state_q == HOLD);
      sensor_fault = (state_q == FAULT);
   end

   assign low          = out_q[2];
   assign mid          = out_q[1];
   assign high         = out_q[0];
   assign level_change = change_q;

endmodule

// File: tb/tb_water_level_sensor_conditioner.sv
// tb/tb_water_level_sensor_conditioner.sv - scenario and randomized checks against a behavioural level model
module tb_water_level_sensor_conditioner;

   localparam int D = 4;
   localparam int F = 8;
   localparam int M_INIT = 0, M_RUN = 1, M_HOLD = 2, M_FAULT = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic probe_low_raw = 1'b0, probe_mid_raw = 1'b0, probe_high_raw = 1'b0;
   logic low, mid, high, level_valid, level_change, sensor_fault;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: probe pipelines, mismatch run lengths, mode, output level
   logic [2:0] m_s1, m_s2, m_st, m_out;
   int         m_run [3];
   int         m_mode, m_age, m_bad;
   logic       m_chg;

   always #5 clk = ~clk;

   water_level_sensor_conditioner #(.DEBOUNCE_CYCLES(D), .FAULT_CYCLES(F)) dut (
      .clk(clk), .reset(reset),
      .probe_low_raw(probe_low_raw), .probe_mid_raw(probe_mid_raw), .probe_high_raw(probe_high_raw),
      .low(low), .mid(mid), .high(high),
      .level_valid(level_valid), .level_change(level_change), .sensor_fault(sensor_fault));

   function automatic logic [2:0] outs();
      return {low, mid, high};
   endfunction

   function automatic bit thermo_ok(input logic [2:0] p);
      return (p == 3'b000) || (p == 3'b100) || (p == 3'b110) || (p == 3'b111);
   endfunction

   task automatic model_edge();
      logic [2:0] raw, s_old, prev_out;
      raw      = {probe_low_raw, probe_mid_raw, probe_high_raw};
      s_old    = m_st;
      prev_out = m_out;
      if (reset) begin
         m_s1 = 0; m_s2 = 0; m_st = 0; m_out = 0; m_chg = 0;
         for (int i = 0; i < 3; i++) m_run[i] = 0;
         m_mode = M_INIT; m_age = 0; m_bad = 0;
         return;
      end
      for (int i = 0; i < 3; i++) begin
         if (m_s2[i] != m_st[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == D) begin
               m_st[i]  = m_s2[i];
               m_run[i] = 0;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_s2 = m_s1;
      m_s1 = raw;
      if (m_age < D + 2) m_age = m_age + 1;
      case (m_mode)
         M_INIT: if (m_age == D + 2) begin
            m_mode = thermo_ok(s_old) ? M_RUN : M_HOLD;
            m_bad  = 0;
         end
         M_RUN: if (!thermo_ok(s_old)) begin
            m_mode = M_HOLD;
            m_bad  = 0;
         end
         M_HOLD: begin
            if (thermo_ok(s_old)) m_mode = M_RUN;
            else begin
               m_bad = m_bad + 1;
               if (m_bad == F) m_mode = M_FAULT;
            end
         end
         default: ;
      endcase
      if (m_mode == M_FAULT)    m_out = 3'b111;
      else if (m_mode == M_RUN) m_out = s_old;
      m_chg = (m_out != prev_out);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_raw(input logic [2:0] p);
      {probe_low_raw, probe_mid_raw, probe_high_raw} = p;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      set_raw(3'b000);
      do_reset(3);
      n_checks++;
      if ({outs(), level_valid, level_change, sensor_fault} !== 6'b000000) begin
         n_fail++;
         $display("FAIL reset_state: got %b required 000000", {outs(), level_valid, level_change, sensor_fault});
      end
      for (int k = 1; k <= D + 2; k++) begin
         tick();
         n_checks++;
         if (outs() !== 3'b000 || level_change !== 1'b0) begin
            n_fail++;
            $display("FAIL init_quiet k=%0d: got out=%b chg=%b required 000/0", k, outs(), level_change);
         end
         if (k == D + 1) begin
            n_checks++;
            if (level_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL init_valid_early: got %b required 0", level_valid);
            end
         end
         if (k == D + 2) begin
            n_checks++;
            if (level_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL init_valid_rise: got %b required 1", level_valid);
            end
         end
      end
   endtask

   task automatic test_fill();
      logic [2:0] steps [3];
      logic [2:0] prev;
      int pulses;
      steps = '{3'b100, 3'b110, 3'b111};
      set_raw(3'b000);
      do_reset(2);
      repeat (D + 2) tick();
      for (int s = 0; s < 3; s++) begin
         prev = outs();
         set_raw(steps[s]);
         pulses = 0;
         for (int k = 1; k <= 20; k++) begin
            tick();
            if (level_change === 1'b1) pulses++;
            n_checks++;
            if (k <= D + 2 && outs() !== prev) begin
               n_fail++;
               $display("FAIL fill_early step=%0d k=%0d: got %b required %b", s, k, outs(), prev);
            end else if (k > D + 2 && outs() !== steps[s]) begin
               n_fail++;
               $display("FAIL fill_level step=%0d k=%0d: got %b required %b", s, k, outs(), steps[s]);
            end
            if (k == D + 3) begin
               n_checks++;
               if (level_change !== 1'b1) begin
                  n_fail++;
                  $display("FAIL fill_change_pulse step=%0d: got %b required 1", s, level_change);
               end
            end
         end
         n_checks++;
         if (pulses != 1 || sensor_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_pulse_count step=%0d: got pulses=%0d fault=%b required 1/0", s, pulses, sensor_fault);
         end
      end
   endtask

   task automatic test_glitch();
      set_raw(3'b000);
      do_reset(2);
      repeat (D + 2) tick();
      set_raw(3'b100);
      repeat (3) tick();
      set_raw(3'b000);
      for (int k = 0; k < 15; k++) begin
         tick();
         n_checks++;
         if (outs() !== 3'b000 || level_change !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch k=%0d: got out=%b chg=%b required 000/0", k, outs(), level_change);
         end
      end
   endtask

   task automatic test_invalid_hold();
      set_raw(3'b000);
      do_reset(2);
      repeat (D + 2) tick();
      set_raw(3'b100);
      repeat (20) tick();
      set_raw(3'b101);
      repeat (5) tick();
      set_raw(3'b111);
      for (int k = 1; k <= 20; k++) begin
         tick();
         n_checks++;
         if (sensor_fault !== 1'b0 || level_valid !== 1'b1 || outs() === 3'b101 || outs() !== m_out) begin
            n_fail++;
            $display("FAIL hold_recover k=%0d: got out=%b valid=%b fault=%b required out=%b valid=1 fault=0",
                     k, outs(), level_valid, sensor_fault, m_out);
         end
         if (k == 5) begin
            n_checks++;
            if (outs() !== 3'b100) begin
               n_fail++;
               $display("FAIL hold_keeps_last: got %b required 100", outs());
            end
         end
      end
      n_checks++;
      if (outs() !== 3'b111) begin
         n_fail++;
         $display("FAIL hold_to_run: got %b required 111", outs());
      end
   endtask

   task automatic test_fault();
      set_raw(3'b000);
      do_reset(2);
      set_raw(3'b001);
      for (int k = 1; k <= D + F + 8; k++) begin
         tick();
         n_checks++;
         if (sensor_fault !== (m_mode == M_FAULT) || outs() !== m_out) begin
            n_fail++;
            $display("FAIL fault_timing k=%0d: got fault=%b out=%b required fault=%b out=%b",
                     k, sensor_fault, outs(), m_mode == M_FAULT, m_out);
         end
      end
      n_checks++;
      if ({sensor_fault, level_valid, outs()} !== 5'b10111) begin
         n_fail++;
         $display("FAIL fault_latched: got %b required 10111", {sensor_fault, level_valid, outs()});
      end
      set_raw(3'b110);
      repeat (20) tick();
      n_checks++;
      if ({sensor_fault, level_valid, outs()} !== 5'b10111) begin
         n_fail++;
         $display("FAIL fault_sticky: got %b required 10111", {sensor_fault, level_valid, outs()});
      end
      do_reset(1);
      n_checks++;
      if ({sensor_fault, level_valid, outs(), level_change} !== 6'b000000) begin
         n_fail++;
         $display("FAIL fault_cleared: got %b required 000000", {sensor_fault, level_valid, outs(), level_change});
      end
   endtask

   task automatic test_reset_mid();
      set_raw(3'b000);
      do_reset(2);
      repeat (D + 2) tick();
      set_raw(3'b100);
      repeat (4) tick();
      do_reset(1);
      for (int k = 1; k <= 20; k++) begin
         tick();
         n_checks++;
         if ((k <= D + 2 && outs() !== 3'b000) || outs() !== m_out || level_change !== m_chg) begin
            n_fail++;
            $display("FAIL reset_mid_debounce k=%0d: got out=%b chg=%b required out=%b chg=%b",
                     k, outs(), level_change, m_out, m_chg);
         end
      end
      set_raw(3'b101);
      repeat (D + 5) tick();
      do_reset(1);
      n_checks++;
      if ({outs(), level_valid, level_change, sensor_fault} !== 6'b000000) begin
         n_fail++;
         $display("FAIL reset_mid_hold: got %b required 000000", {outs(), level_valid, level_change, sensor_fault});
      end
      set_raw(3'b000);
      for (int k = 1; k <= 30; k++) begin
         tick();
         n_checks++;
         if (sensor_fault !== 1'b0 || outs() !== 3'b000 || level_change !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_hold_after k=%0d: got out=%b chg=%b fault=%b required 000/0/0",
                     k, outs(), level_change, sensor_fault);
         end
      end
   endtask

   task automatic test_random();
      logic [2:0] table_v [4];
      logic [2:0] p;
      int hold;
      table_v = '{3'b000, 3'b100, 3'b110, 3'b111};
      for (int seg = 0; seg < 120; seg++) begin
         if ($urandom_range(0, 99) < 5) do_reset($urandom_range(1, 3));
         if ($urandom_range(0, 99) < 85) p = table_v[$urandom_range(0, 3)];
         else p = 3'($urandom_range(0, 7));
         set_raw(p);
         hold = $urandom_range(1, 25);
         for (int k = 0; k < hold; k++) begin
            tick();
            n_checks++;
            if ({outs(), level_valid, level_change, sensor_fault} !==
                {m_out, (m_mode == M_RUN) || (m_mode == M_HOLD), m_chg, m_mode == M_FAULT}) begin
               n_fail++;
               $display("FAIL random seg=%0d: got out=%b v=%b c=%b f=%b required out=%b v=%b c=%b f=%b",
                        seg, outs(), level_valid, level_change, sensor_fault, m_out,
                        (m_mode == M_RUN) || (m_mode == M_HOLD), m_chg, m_mode == M_FAULT);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_glitch();
      test_invalid_hold();
      test_fault();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
